// File: rtl/bnn_fc_scheduler_pkg.sv
// Shared types and width helpers for the binary fully-connected layer scheduler.
package bnn_fc_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WLATCH,
    COMPUTE,
    EMIT
  } state_t;

  // Signed accumulator width: holds +/- IN_DIM * (2^CH_CNT - 1) with a sign bit.
  function automatic int acc_width(input int in_dim, input int ch_cnt);
    return $clog2(in_dim + 1) + ch_cnt + 1;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bnn_fc_scheduler_if.sv
// Input, weight-memory and result channels of the scheduler, bundled together.
// The slave modport is the scheduler itself; master is the surrounding system.
interface bnn_fc_scheduler_if
  import bnn_fc_scheduler_pkg::*;
#(
  parameter int IN_DIM    = 16,
  parameter int OUT_DIM   = 8,
  parameter int BIT_WIDTH = 4,
  parameter int CH_CNT    = 4
);
  localparam int ACC_W = acc_width(IN_DIM, CH_CNT);
  localparam int IDX_W = idx_width(OUT_DIM);

  logic                        in_valid;
  logic                        in_ready;
  logic [IN_DIM*BIT_WIDTH-1:0] value_in;
  logic                        w_rd_en;
  logic [IDX_W-1:0]            w_addr;
  logic [IN_DIM-1:0]           w_rdata;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_W-1:0]            out_data;
  logic [IDX_W-1:0]            out_idx;
  logic                        out_last;
  logic                        busy;

  modport slave (
    input  in_valid, value_in, w_rdata, out_ready,
    output in_ready, w_rd_en, w_addr, out_valid, out_data, out_idx, out_last, busy
  );

  modport master (
    output in_valid, value_in, w_rdata, out_ready,
    input  in_ready, w_rd_en, w_addr, out_valid, out_data, out_idx, out_last, busy
  );

endinterface

// File: rtl/bnn_fc_scheduler_xnor_popcount_plane.sv
// One bit-plane contribution: (2*popcount(xnor(weight, plane)) - IN_DIM) << shift.
module xnor_popcount_plane #(
  parameter int IN_DIM = 16,
  parameter int ACC_W  = 10,
  parameter int SH_W   = 2
) (
  input  logic [IN_DIM-1:0]       weight,
  input  logic [IN_DIM-1:0]       plane,
  input  logic [SH_W-1:0]         shift,
  output logic signed [ACC_W-1:0] term
);
  localparam int CNT_W = $clog2(IN_DIM + 1);

  logic [CNT_W-1:0]        pop;
  logic signed [ACC_W-1:0] base;

  // Count positions where the weight bit agrees with the plane bit.
  always_comb begin
    pop = '0;
    for (int j = 0; j < IN_DIM; j++) begin
      pop = pop + CNT_W'(~(weight[j] ^ plane[j]));
    end
  end

  assign base = signed'({{(ACC_W - CNT_W - 1){1'b0}}, pop, 1'b0}) - signed'(ACC_W'(IN_DIM));
  assign term = base <<< shift;

endmodule

// File: rtl/bnn_fc_scheduler.sv
// Sequences one binary fully-connected layer: fetch a weight row per neuron,
// accumulate one bit-plane per cycle, then hand the signed sum out.
module bnn_fc_scheduler
  import bnn_fc_scheduler_pkg::*;
#(
  parameter int IN_DIM    = 16,
  parameter int OUT_DIM   = 8,
  parameter int BIT_WIDTH = 4,
  parameter int CH_CNT    = 4
) (
  input logic              clk,
  input logic              rst_n,
  bnn_fc_scheduler_if.slave bus
);
  localparam int ACC_W = acc_width(IN_DIM, CH_CNT);
  localparam int IDX_W = idx_width(OUT_DIM);
  localparam int CH_W  = idx_width(CH_CNT);
  localparam int VAL_W = IN_DIM * BIT_WIDTH;

  state_t                  state, state_nxt;
  logic [VAL_W-1:0]        value_reg;
  logic [IN_DIM-1:0]       w_reg;
  logic [IN_DIM-1:0]       plane;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic [CH_W-1:0]         ch_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    last_idx;
  logic                    last_ch;

  assign last_idx = (idx == IDX_W'(OUT_DIM - 1));
  assign last_ch  = (ch_cnt == CH_W'(CH_CNT - 1));

  // Bit-plane c collects bit c of every input element.
  for (genvar j = 0; j < IN_DIM; j++) begin : g_plane
    logic [CH_CNT-1:0] elem_bits;
    assign elem_bits = value_reg[j*BIT_WIDTH +: CH_CNT];
    assign plane[j]  = elem_bits[ch_cnt];
  end

  xnor_popcount_plane #(
    .IN_DIM(IN_DIM),
    .ACC_W (ACC_W),
    .SH_W  (CH_W)
  ) u_plane (
    .weight(w_reg),
    .plane (plane),
    .shift (ch_cnt),
    .term  (term)
  );

  // State register; reset abandons any layer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/control outputs, decoded from the current state.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.w_rd_en   = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_nxt = FETCH;
      end
      FETCH: begin
        bus.w_rd_en = 1'b1;
        state_nxt   = WLATCH;
      end
      WLATCH: state_nxt = COMPUTE;
      COMPUTE: begin
        if (last_ch) state_nxt = EMIT;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_idx;
        if (bus.out_ready) state_nxt = last_idx ? IDLE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: input/weight capture, per-plane accumulation and neuron stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= '0;
      w_reg     <= '0;
      acc       <= '0;
      ch_cnt    <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            value_reg <= bus.value_in;
            idx       <= '0;
          end
        end
        WLATCH: begin
          w_reg  <= bus.w_rdata;
          acc    <= '0;
          ch_cnt <= '0;
        end
        COMPUTE: begin
          acc <= acc + term;
          if (!last_ch) ch_cnt <= ch_cnt + 1'b1;
        end
        EMIT: begin
          if (bus.out_ready && !last_idx) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.w_addr   = idx;
  assign bus.out_idx  = idx;
  assign bus.out_data = acc;

endmodule

// File: doc/bnn_fc_scheduler.md
BNN_FC_SCHEDULER -- requirements
Module: bnn_fc_scheduler

Interface
REQ-001 SHALL have parameter IN_DIM, default 16, input vector length.
REQ-002 SHALL have parameter OUT_DIM, default 8, number of output neurons.
REQ-003 SHALL have parameter BIT_WIDTH, default 4, bits per input element.
REQ-004 SHALL have parameter CH_CNT, default 4 (<= BIT_WIDTH), number of bit-plane channels.
REQ-005 SHALL have ports: clk  input  1  single clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: in_valid  input  1; in_ready  output  1; value_in  input  IN_DIM*BIT_WIDTH  unsigned input vector.
REQ-007 SHALL have ports: w_rd_en  output  1; w_addr  output  clog2(OUT_DIM)  neuron index; w_rdata  input  IN_DIM  binary weight row, valid the cycle after w_rd_en.
REQ-008 SHALL have ports: out_valid  output  1; out_ready  input  1; out_data  output  ACC_W  signed result; out_idx  output  clog2(OUT_DIM); out_last  output  1; busy  output  1.

Function
REQ-009 SHALL define ACC_W = clog2(IN_DIM+1) + CH_CNT + 1.
REQ-010 SHALL use an FSM with states IDLE, FETCH, WLATCH, COMPUTE, EMIT.
REQ-011 SHALL assert in_ready only in IDLE; on in_valid&&in_ready, SHALL latch value_in, clear neuron index to 0, and go to FETCH.
REQ-012 FETCH SHALL assert w_rd_en for exactly one cycle with w_addr = neuron index, then go to WLATCH.
REQ-013 WLATCH SHALL capture w_rdata into a weight register, clear the accumulator and channel counter, then go to COMPUTE.
REQ-014 Each COMPUTE cycle c (0..CH_CNT-1) SHALL add (2*popcount(~(w_reg ^ plane_c)) - IN_DIM) << c to the signed accumulator, where plane_c bit j = bit c of element j.
REQ-015 After COMPUTE cycle CH_CNT-1, the FSM SHALL go to EMIT.
REQ-016 EMIT SHALL drive out_valid=1, out_data=accumulator, out_idx=neuron index, and out_last=(index==OUT_DIM-1), all held stable until out_ready.
REQ-017 On out_valid&&out_ready, the FSM SHALL go to IDLE if out_last, else increment the index and go to FETCH.
REQ-018 Latency SHALL be: accept at cycle 0, first out_valid at cycle 3+CH_CNT, and each subsequent out_valid CH_CNT+3 cycles after the previous handshake (zero back-pressure).
REQ-019 With OUT_DIM=1, the first output SHALL carry out_last=1.
REQ-020 The accumulator SHALL never overflow: range is +/-IN_DIM*(2^CH_CNT-1).
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 w_rd_en SHALL be 0 outside FETCH.
REQ-023 in_valid outside IDLE SHALL be ignored.
REQ-024 value_in changes after acceptance SHALL have no effect on results.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE; in_ready=1 after release; out_valid, w_rd_en, busy, out_last=0; out_data, out_idx, w_addr, accumulator, counters=0.
REQ-026 Reset mid-operation SHALL discard the layer in progress; no output SHALL appear until a new input is accepted.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and the ACC_W / index-width functions.
REQ-028 Popcount-and-scale SHALL be one combinational sub-module, xnor_popcount_plane.

Verification (IN_DIM=4, CH_CNT=2, BIT_WIDTH=2, OUT_DIM=2 unless stated)
REQ-029 Values {3,3,3,3}, weights 4'b1111 for both rows -> out_data=12 for idx 0 and 1; out_last=1 on idx 1 only; first out_valid at cycle 5.
REQ-030 Values {3,3,3,3}, weights 4'b0000 -> out_data=-12 for both outputs.
REQ-031 Values {e0=1,e1=2,e2=0,e3=3} (planes 1001, 1010), weight 4'b1111 -> out_data=0; weight 4'b1001 -> (4 + 0*2) = 4.
REQ-032 Hold out_ready=0 for 5 cycles in EMIT -> out_valid, out_data, out_idx stable; no w_rd_en pulse; next FETCH the cycle after the handshake.
REQ-033 Assert rst_n=0 during COMPUTE of idx 1 -> immediate IDLE, in_ready=1 and out_valid=0 after release; a new run yields correct results from idx 0.
REQ-034 Pulse in_valid while busy -> ignored; in_ready stays 0; results unaffected.
